// File: rtl/data_sync_transmitter_pkg.sv
// Shared definitions for the data sync transmitter/receiver pair.
// Holds the 2-bit handshake FSM encodings and the timeout counter width.
package data_sync_transmitter_pkg;
  localparam int         CNT_W      = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_REQUEST = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;
endpackage

// File: rtl/data_sync_transmitter_bit_synchronizer.sv
// Multi-flop single-bit synchronizer for a level crossing into clk.
module bit_synchronizer #(
  parameter int STAGE_COUNT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);
  logic [STAGE_COUNT-1:0] r_sync;

  // Shift the asynchronous level through the flop chain; MSB is the output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sync <= '0;
    else        r_sync <= {r_sync[STAGE_COUNT-2:0], async_in};
  end

  assign sync_out = r_sync[STAGE_COUNT-1];
endmodule

// File: rtl/data_sync_transmitter.sv
// Source side of a 4-phase request/acknowledge crossing.
// A word is captured in IDLE, held stable while the request level is raised,
// and released once the synchronized acknowledge has risen and fallen again.
// A timeout aborts a stalled handshake; RECOVER waits for a quiet acknowledge.
module data_sync_transmitter
  import data_sync_transmitter_pkg::*;
#(
  parameter int STAGE_COUNT    = 2,
  parameter int BUS_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] parallel_data,
  input  logic                 parallel_data_valid,
  output logic                 ready,
  input  logic                 acknowledge,
  output logic [BUS_WIDTH-1:0] asynchronous_data,
  output logic                 asynchronous_data_valid,
  output logic                 transfer_done,
  output logic                 timeout_error
);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_quiet;
  logic [BUS_WIDTH-1:0] r_data;
  logic                 r_vld;
  logic                 r_done;
  logic                 r_to;

  logic       w_ack_s;
  logic [1:0] w_next;
  logic       w_cap;
  logic       w_vld_clr;
  logic       w_done;
  logic       w_to;
  logic       w_quiet_nxt;
  logic       w_cnt_hit;

  bit_synchronizer #(.STAGE_COUNT(STAGE_COUNT)) u_ack_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (acknowledge),
    .sync_out (w_ack_s)
  );

  assign w_cnt_hit = (r_cnt == TO_LAST);

  // Next-state and event decode; acknowledge exits take priority over timeout.
  always_comb begin
    w_next      = r_state;
    w_cap       = 1'b0;
    w_vld_clr   = 1'b0;
    w_done      = 1'b0;
    w_to        = 1'b0;
    w_quiet_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ack_s) begin
          w_next = ST_RECOVER;           // stale acknowledge: never capture
        end else if (parallel_data_valid) begin
          w_next = ST_REQUEST;
          w_cap  = 1'b1;
        end
      end
      ST_REQUEST: begin
        if (w_ack_s) begin
          w_next    = ST_RELEASE;
          w_vld_clr = 1'b1;
        end else if (w_cnt_hit) begin
          w_next    = ST_RECOVER;
          w_vld_clr = 1'b1;
          w_to      = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!w_ack_s) begin
          w_next = ST_IDLE;
          w_done = 1'b1;
        end else if (w_cnt_hit) begin
          w_next = ST_RECOVER;
          w_to   = 1'b1;
        end
      end
      ST_RECOVER: begin
        // Need two consecutive low acknowledge samples before re-arming.
        if (!w_ack_s) begin
          if (r_quiet) w_next = ST_IDLE;
          else         w_quiet_nxt = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State, quiet qualifier and timeout counter (cleared on any state change).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_quiet <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_quiet <= w_quiet_nxt;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (r_state == ST_REQUEST || r_state == ST_RELEASE)
        r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Launch registers: data changes only on capture, request level is a flop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
      r_vld  <= 1'b0;
      r_done <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      if (w_cap) r_data <= parallel_data;
      if (w_cap)          r_vld <= 1'b1;
      else if (w_vld_clr) r_vld <= 1'b0;
      r_done <= w_done;
      r_to   <= w_to;
    end
  end

  assign ready                   = (r_state == ST_IDLE);
  assign asynchronous_data       = r_data;
  assign asynchronous_data_valid = r_vld;
  assign transfer_done           = r_done;
  assign timeout_error           = r_to;
endmodule
